// File: rtl/hyperbus_rx_pkg.sv
// Shared types and width helpers for the HyperBus read-capture front end.
package hyperbus_rx_pkg;

  typedef enum logic [1:0] {
    RX_FILL,
    RX_STREAM,
    RX_DONE
  } rx_state_e;

  localparam int unsigned DROP_CNT_W = 8;

  // One DDR beat carries a rise and a fall sample from every PHY.
  function automatic int unsigned beat_width(input int unsigned dq_width,
                                             input int unsigned num_phys);
    return num_phys * 2 * dq_width;
  endfunction

  function automatic int unsigned word_width(input int unsigned dq_width,
                                             input int unsigned num_phys,
                                             input int unsigned pack);
    return beat_width(dq_width, num_phys) * pack;
  endfunction

endpackage

// File: rtl/hyperbus_rx_ddr_cap.sv
// DDR capture for one PHY: rise sample on posedge, fall sample on negedge.
// The beat {fall, rise} is consumed by the parent at the following rising edge.
module hyperbus_rx_ddr_cap #(
  parameter int unsigned DQ_WIDTH = 8
) (
  input  logic                  clk_rwds,
  input  logic                  resetReadModule,
  input  logic [DQ_WIDTH-1:0]   dq_i,
  output logic [2*DQ_WIDTH-1:0] beat_o
);

  logic [DQ_WIDTH-1:0] rise_q;
  logic [DQ_WIDTH-1:0] fall_q;

  // Rising-edge sample
  always_ff @(posedge clk_rwds or posedge resetReadModule) begin
    if (resetReadModule) rise_q <= '0;
    else                 rise_q <= dq_i;
  end

  // Falling-edge sample
  always_ff @(negedge clk_rwds or posedge resetReadModule) begin
    if (resetReadModule) fall_q <= '0;
    else                 fall_q <= dq_i;
  end

  assign beat_o = {fall_q, rise_q};

endmodule

// File: rtl/hyperbus_rx_capture.sv
// HyperBus read-capture front end in the RWDS clock domain: DDR capture of
// NUM_PHYS PHYs, beat packing, burst-length tracking and a skid FIFO feeding
// the read CDC FIFO. clk_rwds cannot be stalled, so a full FIFO drops words
// and raises a sticky overflow flag.
// Optional macro HYPERBUS_RX_CAPTURE_STATS_EN enables the saturating drop
// counter and a simulation-only assertion on every drop.
module hyperbus_rx_capture
  import hyperbus_rx_pkg::*;
#(
  parameter int unsigned DQ_WIDTH   = 8,
  parameter int unsigned NUM_PHYS   = 1,
  parameter int unsigned PACK       = 1,
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                                          clk_rwds,
  input  logic                                          resetReadModule,
  input  logic [NUM_PHYS*DQ_WIDTH-1:0]                  dq_i,
  input  logic [LEN_W-1:0]                              cfg_burst_len_i,
  input  logic                                          src_ready_i,
  output logic                                          src_valid_o,
  output logic [word_width(DQ_WIDTH, NUM_PHYS, PACK)-1:0] src_data_o,
  output logic                                          src_last_o,
  output logic                                          overflow_o,
  output logic [LEN_W-1:0]                              word_cnt_o,
  output logic                                          busy_o,
  output logic [DROP_CNT_W-1:0]                         drop_cnt_o
);

  localparam int unsigned BEAT_W = beat_width(DQ_WIDTH, NUM_PHYS);
  localparam int unsigned WORD_W = word_width(DQ_WIDTH, NUM_PHYS, PACK);
  localparam int unsigned PIDX_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned AW     = $clog2(SKID_DEPTH);
  localparam logic [PIDX_W-1:0] PACK_LAST = PIDX_W'(PACK - 1);
  localparam logic [AW:0]       FIFO_FULL = (AW + 1)'(SKID_DEPTH);

  logic [BEAT_W-1:0] beat;

  for (genvar p = 0; p < NUM_PHYS; p++) begin : g_phy
    hyperbus_rx_ddr_cap #(
      .DQ_WIDTH(DQ_WIDTH)
    ) u_cap (
      .clk_rwds       (clk_rwds),
      .resetReadModule(resetReadModule),
      .dq_i           (dq_i[p*DQ_WIDTH +: DQ_WIDTH]),
      .beat_o         (beat[p*2*DQ_WIDTH +: 2*DQ_WIDTH])
    );
  end

  rx_state_e         state_q;
  logic [PIDX_W-1:0] pack_idx_q;
  logic [WORD_W-1:0] pack_q;
  logic [WORD_W-1:0] word_d;
  logic [LEN_W-1:0]  word_cnt_q;
  logic              overflow_q;
  logic              word_push;
  logic              word_last;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // Packer: drop the current beat into its slot; the word completes on the last slot
  always_comb begin
    word_d    = pack_q;
    word_push = 1'b0;
    if (state_q == RX_STREAM) begin
      for (int unsigned k = 0; k < PACK; k++) begin
        if (pack_idx_q == PIDX_W'(k)) word_d[k*BEAT_W +: BEAT_W] = beat;
      end
      word_push = (pack_idx_q == PACK_LAST);
    end
  end

  // Last-word compare uses the wrapped accepted-word count
  assign word_last = (cfg_burst_len_i != '0) && (word_cnt_q == cfg_burst_len_i - LEN_W'(1));

  // FSM, pack index and counters; DONE ignores postamble edges until reset
  always_ff @(posedge clk_rwds or posedge resetReadModule) begin
    if (resetReadModule) begin
      state_q    <= RX_FILL;
      pack_idx_q <= '0;
      pack_q     <= '0;
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        RX_FILL: state_q <= RX_STREAM;
        RX_STREAM: begin
          pack_q     <= word_d;
          pack_idx_q <= word_push ? '0 : pack_idx_q + 1'b1;
          // A dropped last word still ends the burst
          if (word_push && word_last) state_q <= RX_DONE;
        end
        default: ;
      endcase
      if (push_ok) word_cnt_q <= word_cnt_q + LEN_W'(1);
      if (drop)    overflow_q <= 1'b1;
    end
  end

  logic [WORD_W:0] mem_q [SKID_DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [AW:0]     count_q;

  assign full        = (count_q == FIFO_FULL);
  assign src_valid_o = (count_q != '0);
  assign pop         = src_valid_o && src_ready_i;
  // A simultaneous pop frees the slot, so a full FIFO only drops without one
  assign push_ok     = word_push && (!full || pop);
  assign drop        = word_push && full && !pop;

  // Skid FIFO storage and pointers
  always_ff @(posedge clk_rwds or posedge resetReadModule) begin
    if (resetReadModule) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= {word_last, word_d};
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end

  assign {src_last_o, src_data_o} = mem_q[rptr_q];
  assign overflow_o = overflow_q;
  assign word_cnt_o = word_cnt_q;
  assign busy_o     = (state_q != RX_DONE);

`ifdef HYPERBUS_RX_CAPTURE_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Saturating dropped-word counter
  always_ff @(posedge clk_rwds or posedge resetReadModule) begin
    if (resetReadModule)                drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign drop_cnt_o = drop_cnt_q;

`ifndef SYNTHESIS
  // Flag every dropped word in simulation
  always_ff @(posedge clk_rwds) begin
    if (!resetReadModule) begin
      assert (!drop) else $error("hyperbus_rx_capture: word dropped, skid FIFO full");
    end
  end
`endif
`else
  assign drop_cnt_o = '0;
`endif

endmodule
